// File: rtl/phys_freelist_pkg.sv
// ---------------------------------------------------------------------------
// phys_freelist_pkg
//
// Shared constants for the physical register free list and its selector.
//
// Contents:
//   DEFAULT_N          - default dispatch/retire width in lanes
//   DEFAULT_ARCH_COUNT - default number of architectural registers
//   DEFAULT_PHYS_REGS  - default number of physical registers
//   tag_width()        - bit width of a physical register tag
// ---------------------------------------------------------------------------
package phys_freelist_pkg;

    localparam int DEFAULT_N          = 3;
    localparam int DEFAULT_ARCH_COUNT = 32;
    localparam int DEFAULT_PHYS_REGS  = 64;

    // A tag must be able to name every physical register. A file with a
    // single register still needs one bit so that vectors stay legal.
    function automatic int tag_width(input int phys_regs);
        return (phys_regs > 1) ? $clog2(phys_regs) : 1;
    endfunction

endpackage

// File: rtl/freelist_psel.sv
// ---------------------------------------------------------------------------
// freelist_psel
//
// N-way lowest-index-first selector. The k-th requesting lane (counting
// upward from lane 0) receives the k-th lowest set bit of the bitmap.
// Requesting lanes that find no remaining set bit, and lanes that do not
// request, report grant=0 with tag=0. Purely combinational.
//
// Ports:
//   bitmap [PHYS_REGS]   - candidate bits (1 = available)
//   req    [N]           - per-lane request, lane 0 oldest
//   grant  [N]           - lane received a bit
//   tags   [N][TAG_W]    - index of the bit given to each lane
// ---------------------------------------------------------------------------
module freelist_psel
    import phys_freelist_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter int PHYS_REGS = DEFAULT_PHYS_REGS,
    parameter int TAG_W     = tag_width(DEFAULT_PHYS_REGS)
) (
    input  logic [PHYS_REGS-1:0]      bitmap,
    input  logic [N-1:0]              req,
    output logic [N-1:0]              grant,
    output logic [N-1:0][TAG_W-1:0]   tags
);

    logic [PHYS_REGS-1:0] avail;
    logic                 found;

    // Lanes are served in age order. Each granted bit is removed from the
    // working copy so the next requesting lane sees only what is left.
    always_comb begin
        avail = bitmap;
        found = 1'b0;
        grant = '0;
        tags  = '0;
        for (int lane = 0; lane < N; lane++) begin
            found = 1'b0;
            if (req[lane]) begin
                for (int b = 0; b < PHYS_REGS; b++) begin
                    if (!found && avail[b]) begin
                        found       = 1'b1;
                        grant[lane] = 1'b1;
                        tags[lane]  = TAG_W'(b);
                        avail[b]    = 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/phys_freelist.sv
// ---------------------------------------------------------------------------
// phys_freelist
//
// Physical register free list for an R10K-style rename stage. Two bitmaps
// are kept: spec_free is the dispatch view and is consumed by allocation,
// arch_free is the committed view and is only changed by retirement. A
// mispredict restores the dispatch view from the committed view.
//
// Ports:
//   clock              - sole clock, rising edge
//   reset              - asynchronous, active-low reset
//   alloc_req [N]      - per-lane allocation request, lane 0 oldest
//   alloc_valid [N]    - lane granted a physical register this cycle
//   alloc_tags [N]     - granted tag per lane (0 when not granted)
//   free_count         - popcount of spec_free
//   retire_free_mask   - old tags released by retire this cycle
//   retire_commit_mask - new tags committed to the architectural map
//   mispredict         - flush from retire, restores spec_free
//   double_free_dbg    - sticky: a freed bit was already free
// ---------------------------------------------------------------------------
module phys_freelist
    import phys_freelist_pkg::*;
#(
    parameter  int N          = DEFAULT_N,
    parameter  int ARCH_COUNT = DEFAULT_ARCH_COUNT,
    parameter  int PHYS_REGS  = DEFAULT_PHYS_REGS,
    localparam int TAG_W      = tag_width(PHYS_REGS),
    localparam int CNT_W      = $clog2(PHYS_REGS + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0]              alloc_req,
    output logic [N-1:0]              alloc_valid,
    output logic [N-1:0][TAG_W-1:0]   alloc_tags,
    output logic [CNT_W-1:0]          free_count,
    input  logic [PHYS_REGS-1:0]      retire_free_mask,
    input  logic [PHYS_REGS-1:0]      retire_commit_mask,
    input  logic                      mispredict,
    output logic                      double_free_dbg
);

    // Identity map at reset: architectural registers 0..ARCH_COUNT-1 are
    // held by physical registers of the same index, the rest are free.
    localparam logic [PHYS_REGS-1:0] RESET_MAP   = {PHYS_REGS{1'b1}} << ARCH_COUNT;
    localparam logic [CNT_W-1:0]     RESET_COUNT = CNT_W'(PHYS_REGS - ARCH_COUNT);

    // PR0 is the hardwired zero register and must never become free.
    localparam logic [PHYS_REGS-1:0] NO_PR0_MASK = {{(PHYS_REGS-1){1'b1}}, 1'b0};

    logic [PHYS_REGS-1:0]     spec_free;
    logic [PHYS_REGS-1:0]     arch_free;
    logic [PHYS_REGS-1:0]     spec_free_next;
    logic [PHYS_REGS-1:0]     arch_free_next;
    logic [PHYS_REGS-1:0]     free_eff;
    logic [PHYS_REGS-1:0]     grant_mask;
    logic [CNT_W-1:0]         count_next;
    logic                     double_hit;
    logic [N-1:0]             grant_raw;
    logic [N-1:0][TAG_W-1:0]  tags_raw;

    freelist_psel #(
        .N         (N),
        .PHYS_REGS (PHYS_REGS),
        .TAG_W     (TAG_W)
    ) u_psel (
        .bitmap (spec_free),
        .req    (alloc_req),
        .grant  (grant_raw),
        .tags   (tags_raw)
    );

    // Grants are silenced while reset is held so dispatch never sees a tag
    // from a list that is being reinitialised.
    assign alloc_valid = reset ? grant_raw : '0;
    assign alloc_tags  = reset ? tags_raw  : '0;

    // Bits handed out this cycle, to be cleared from spec_free at the edge.
    always_comb begin
        grant_mask = '0;
        for (int lane = 0; lane < N; lane++) begin
            if (grant_raw[lane]) begin
                grant_mask[tags_raw[lane]] = 1'b1;
            end
        end
    end

    // Next-state bitmaps. A mispredict reloads the dispatch view from the
    // committed view (including this cycle's retirement) and drops any
    // grants made in the same cycle. Otherwise grants and frees of distinct
    // bits both apply; freed bits are only visible to the selector from the
    // following cycle, so there is no same-cycle bypass.
    always_comb begin
        free_eff       = retire_free_mask & NO_PR0_MASK;
        arch_free_next = (arch_free | free_eff) & ~retire_commit_mask & NO_PR0_MASK;
        if (mispredict) begin
            spec_free_next = arch_free_next;
        end else begin
            spec_free_next = ((spec_free & ~grant_mask) | free_eff) & NO_PR0_MASK;
        end
        double_hit = |(free_eff & spec_free);
    end

    // free_count is computed from the next bitmap so that the registered
    // count always matches the registered spec_free with no lag.
    always_comb begin
        count_next = '0;
        for (int b = 0; b < PHYS_REGS; b++) begin
            count_next = count_next + CNT_W'(spec_free_next[b]);
        end
    end

    // State update. Reset discards everything in flight and restores the
    // identity map; the double-free flag is sticky until reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            spec_free       <= RESET_MAP;
            arch_free       <= RESET_MAP;
            free_count      <= RESET_COUNT;
            double_free_dbg <= 1'b0;
        end else begin
            spec_free       <= spec_free_next;
            arch_free       <= arch_free_next;
            free_count      <= count_next;
            double_free_dbg <= double_free_dbg | double_hit;
        end
    end

endmodule
